// File: rtl/mips_mem_access_unit.sv
// Purpose : MIPS load/store unit; one core memory op at a time onto an Avalon-MM master port.
// Latency : accept at edge N, bus access sampled at N+1, resp_valid visible after N+1 (+1 per wait cycle).
// Backpr. : req_ready only in IDLE; the bus side honours waitrequest, with an optional stall timeout.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/req_ready        op handshake; req_op, req_addr, req_wdata, req_rt_old carry the op
//   resp_valid/rdata/error     one-cycle completion pulse with load data or error flag
//   address/read/write/        Avalon-MM master (word-aligned address, byte lanes, write data)
//   byteenable/writedata,
//   waitrequest/readdata
module mips_mem_access_unit #(
  parameter int unsigned WAIT_TIMEOUT = 0,
  parameter int unsigned CNT_W        = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt_old,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LW  = 4'd4;
  localparam logic [3:0] OP_LWL = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SW  = 4'd10;

  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(WAIT_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [1:0]  lane_q, lane_d;
  logic [31:0] rt_old_q, rt_old_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] address_q, address_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] writedata_q, writedata_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic        resp_valid_q, resp_valid_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_error_q, resp_error_d;

  // Decode of the incoming request (only used in IDLE).
  logic        req_legal, req_store, req_misaligned;
  logic [3:0]  req_be;
  logic [31:0] req_wd;

  always_comb begin
    req_legal      = 1'b1;
    req_store      = 1'b0;
    req_misaligned = 1'b0;
    req_be         = 4'b1111;
    req_wd         = req_wdata;
    unique case (req_op)
      OP_LB, OP_LBU: req_be = 4'b0001 << req_addr[1:0];
      OP_LH, OP_LHU: begin
        req_be         = req_addr[1] ? 4'b1100 : 4'b0011;
        req_misaligned = req_addr[0];
      end
      OP_LW:         req_misaligned = (req_addr[1:0] != 2'b00);
      OP_LWL, OP_LWR: req_be = 4'b1111;
      OP_SB: begin
        req_store = 1'b1;
        req_be    = 4'b0001 << req_addr[1:0];
        req_wd    = {4{req_wdata[7:0]}};
      end
      OP_SH: begin
        req_store      = 1'b1;
        req_be         = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wd         = {2{req_wdata[15:0]}};
        req_misaligned = req_addr[0];
      end
      OP_SW: begin
        req_store      = 1'b1;
        req_misaligned = (req_addr[1:0] != 2'b00);
      end
      default:       req_legal = 1'b0;
    endcase
  end

  // Load result from the bus word, the latched lane and the old rt (LWL/LWR merge).
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;

  always_comb begin
    ld_result = 32'd0;
    unique case (lane_q)
      2'd0:    ld_byte = readdata[7:0];
      2'd1:    ld_byte = readdata[15:8];
      2'd2:    ld_byte = readdata[23:16];
      default: ld_byte = readdata[31:24];
    endcase
    ld_half = lane_q[1] ? readdata[31:16] : readdata[15:0];
    unique case (op_q)
      OP_LB:  ld_result = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU: ld_result = {24'd0, ld_byte};
      OP_LH:  ld_result = {{16{ld_half[15]}}, ld_half};
      OP_LHU: ld_result = {16'd0, ld_half};
      OP_LW:  ld_result = readdata;
      OP_LWL: begin
        unique case (lane_q)
          2'd0:    ld_result = {readdata[7:0],  rt_old_q[23:0]};
          2'd1:    ld_result = {readdata[15:0], rt_old_q[15:0]};
          2'd2:    ld_result = {readdata[23:0], rt_old_q[7:0]};
          default: ld_result = readdata;
        endcase
      end
      OP_LWR: begin
        unique case (lane_q)
          2'd0:    ld_result = readdata;
          2'd1:    ld_result = {rt_old_q[31:24], readdata[31:8]};
          2'd2:    ld_result = {rt_old_q[31:16], readdata[31:16]};
          default: ld_result = {rt_old_q[31:8],  readdata[31:24]};
        endcase
      end
      default: ld_result = 32'd0;   // stores return zero
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    lane_d       = lane_q;
    rt_old_d     = rt_old_q;
    cnt_d        = cnt_q;
    address_d    = address_q;
    read_d       = read_q;
    write_d      = write_q;
    writedata_d  = writedata_q;
    byteenable_d = byteenable_q;
    // Response fields are single-cycle: only set on the transition into RESP.
    resp_valid_d = 1'b0;
    resp_rdata_d = 32'd0;
    resp_error_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d     = req_op;
          lane_d   = req_addr[1:0];
          rt_old_d = req_rt_old;
          cnt_d    = '0;
          if (!req_legal || req_misaligned) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            state_d      = ST_ACCESS;
            address_d    = {req_addr[31:2], 2'b00};
            byteenable_d = req_be;
            writedata_d  = req_wd;
            read_d       = !req_store;
            write_d      = req_store;
          end
        end
      end
      ST_ACCESS: begin
        if (!waitrequest) begin
          read_d       = 1'b0;
          write_d      = 1'b0;
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = ld_result;
        end else if ((WAIT_TIMEOUT != 0) && (cnt_q + CNT_ONE == CNT_LIMIT)) begin
          // This edge is the WAIT_TIMEOUT-th stalled one: give up on the access.
          read_d       = 1'b0;
          write_d      = 1'b0;
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;   // saturates so an unlimited wait never wraps
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= 4'd0;
      lane_q       <= 2'd0;
      rt_old_q     <= 32'd0;
      cnt_q        <= '0;
      address_q    <= 32'd0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= 32'd0;
      byteenable_q <= 4'd0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      lane_q       <= lane_d;
      rt_old_q     <= rt_old_d;
      cnt_q        <= cnt_d;
      address_q    <= address_d;
      read_q       <= read_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      byteenable_q <= byteenable_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_error_q <= resp_error_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_error = resp_error_q;
  assign address    = address_q;
  assign read       = read_q;
  assign write      = write_q;
  assign writedata  = writedata_q;
  assign byteenable = byteenable_q;

endmodule
